mole_scheduler: RTL

//  Schedules mole pop-ups across NUM_HOLES LED/button holes while game control enables it (PLAYING).

---
 rtl/whack_pkg.sv | 30 +++
 rtl/mole_lfsr.sv | 42 ++++
 rtl/mole_scheduler.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole datapath: difficulty codes, default timings,
// scheduler states and the LFSR seed guard.
package whack_pkg;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  localparam int ON_EASY_MS  = 1000;
  localparam int ON_MED_MS   = 700;
  localparam int ON_HARD_MS  = 450;
  localparam int GAP_BASE_MS = 300;

  // Width of every millisecond length and counter in the scheduler
  localparam int MS_W = 11;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } sched_state_t;

  // An all-zero Galois LFSR never leaves zero, so such a seed is swapped out
  function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11) with step enable and zero-lock recovery.
// The low OUT_W bits are exported so callers only take what they consume.
module mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_rnd
);

  localparam logic [15:0] SEED_EFF = lfsr_seed_fix(SEED);
  localparam logic [15:0] TAPS     = 16'hB400;

  logic [15:0] r_lfsr;
  logic [15:0] w_next;

  if (OUT_W < 1 || OUT_W > 16) begin : g_bad_out_w
    $error("mole_lfsr: OUT_W must be 1..16");
  end

  always_comb begin
    w_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? TAPS : 16'h0000);
    if (r_lfsr == 16'h0000) begin
      w_next = SEED_EFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_EFF;
    end else if (i_en) begin
      r_lfsr <= w_next;
    end
  end

  assign o_rnd = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/mole_scheduler.sv
// Mole pop-up scheduler: random gap, random hole held up for a difficulty-dependent
// time, and registered hit / miss / wrong pulses for the score counter.
module mole_scheduler
  import whack_pkg::*;
#(
  parameter int          NUM_HOLES = 8,
  parameter int          TICK_DIV  = 100000,
  parameter int          ON_EASY   = ON_EASY_MS,
  parameter int          ON_MED    = ON_MED_MS,
  parameter int          ON_HARD   = ON_HARD_MS,
  parameter int          GAP_BASE  = GAP_BASE_MS,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic [1:0]           i_difficulty,
  input  logic [NUM_HOLES-1:0] i_hit_btn,
  output logic [NUM_HOLES-1:0] o_mole_leds,
  output logic                 o_mole_active,
  output logic                 o_hit_pulse,
  output logic                 o_miss_pulse,
  output logic                 o_wrong_pulse
);

  localparam int HW      = $clog2(NUM_HOLES);
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_MAX = GAP_BASE + 255;
  localparam int LEN_MAX = (GAP_MAX > ON_EASY) ? GAP_MAX : ON_EASY;

  localparam logic [PW-1:0]        TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0  = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  if (NUM_HOLES < 2 || NUM_HOLES > 16 || (NUM_HOLES & (NUM_HOLES - 1)) != 0) begin : g_bad_holes
    $error("mole_scheduler: NUM_HOLES must be a power of two in 2..16");
  end
  if (TICK_DIV < 1) begin : g_bad_tick
    $error("mole_scheduler: TICK_DIV must be at least 1");
  end
  if (LEN_MAX >= (1 << MS_W) || ON_MED >= (1 << MS_W) || ON_HARD >= (1 << MS_W)) begin : g_bad_len
    $error("mole_scheduler: gap/on lengths do not fit the 11-bit ms counter");
  end

  sched_state_t         r_state, w_nxt_state;
  logic [PW-1:0]        r_presc;
  logic                 w_tick;
  logic [7:0]           w_rnd;

  logic [MS_W-1:0]      r_ms, w_nxt_ms, w_ms_inc;
  logic [MS_W-1:0]      r_gap_len, w_nxt_gap, w_gap_new;
  logic [MS_W-1:0]      r_on_len, w_nxt_on, w_on_sel;
  logic [HW-1:0]        r_hole, w_nxt_hole, w_pick;
  logic [HW-1:0]        r_prev, w_nxt_prev;

  logic [NUM_HOLES-1:0] r_leds, w_nxt_leds;
  logic                 r_active, w_nxt_active;
  logic                 r_hit, w_nxt_hit;
  logic                 r_miss, w_nxt_miss;
  logic                 r_wrong, w_nxt_wrong;
  logic                 w_hit_any, w_wrong_any;

  mole_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (8)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (i_enable),
    .o_rnd (w_rnd)
  );

  // Prescaler is held at zero in IDLE so a fresh GAP is aligned to whole ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (!i_enable || r_state == IDLE || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  assign w_tick    = (r_state != IDLE) && (r_presc == TICK_LAST);
  assign w_ms_inc  = r_ms + MS_W'(1);
  assign w_gap_new = MS_W'(GAP_BASE) + MS_W'(w_rnd);

  always_comb begin
    case (i_difficulty)
      DIFF_EASY: w_on_sel = MS_W'(ON_EASY);
      DIFF_MED:  w_on_sel = MS_W'(ON_MED);
      default:   w_on_sel = MS_W'(ON_HARD);
    endcase
  end

  // Never show the same hole twice in a row; HW-bit add wraps modulo NUM_HOLES
  assign w_pick = (w_rnd[HW-1:0] == r_prev) ? (w_rnd[HW-1:0] + HW'(1)) : w_rnd[HW-1:0];

  assign w_hit_any   = |(i_hit_btn & r_leds);
  assign w_wrong_any = |(i_hit_btn & ~r_leds);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_ms     = r_ms;
    w_nxt_gap    = r_gap_len;
    w_nxt_on     = r_on_len;
    w_nxt_hole   = r_hole;
    w_nxt_prev   = r_prev;
    w_nxt_leds   = '0;
    w_nxt_active = 1'b0;
    w_nxt_hit    = 1'b0;
    w_nxt_miss   = 1'b0;
    w_nxt_wrong  = 1'b0;

    if (!i_enable) begin
      w_nxt_state = IDLE;
      w_nxt_ms    = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_nxt_state = GAP;
          w_nxt_ms    = '0;
          w_nxt_gap   = w_gap_new;
        end

        GAP: begin
          if (w_tick) begin
            if (w_ms_inc >= r_gap_len) begin
              w_nxt_state  = UP;
              w_nxt_ms     = '0;
              w_nxt_hole   = w_pick;
              w_nxt_on     = w_on_sel;
              w_nxt_leds   = ONE_HOT0 << w_pick;
              w_nxt_active = 1'b1;
            end else begin
              w_nxt_ms = w_ms_inc;
            end
          end
        end

        UP: begin
          // A correct press outranks both a concurrent wrong press and a timeout
          if (w_hit_any) begin
            w_nxt_hit   = 1'b1;
            w_nxt_state = GAP;
            w_nxt_ms    = '0;
            w_nxt_prev  = r_hole;
            w_nxt_gap   = w_gap_new;
          end else begin
            w_nxt_wrong = w_wrong_any;
            if (w_tick && (w_ms_inc >= r_on_len)) begin
              w_nxt_miss  = 1'b1;
              w_nxt_state = GAP;
              w_nxt_ms    = '0;
              w_nxt_prev  = r_hole;
              w_nxt_gap   = w_gap_new;
            end else begin
              w_nxt_leds   = r_leds;
              w_nxt_active = 1'b1;
              if (w_tick) begin
                w_nxt_ms = w_ms_inc;
              end
            end
          end
        end

        default: begin
          w_nxt_state = IDLE;
          w_nxt_ms    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms      <= '0;
      r_gap_len <= '0;
      r_on_len  <= '0;
      r_hole    <= '0;
      r_prev    <= '0;
      r_leds    <= '0;
      r_active  <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_wrong   <= 1'b0;
    end else begin
      r_ms      <= w_nxt_ms;
      r_gap_len <= w_nxt_gap;
      r_on_len  <= w_nxt_on;
      r_hole    <= w_nxt_hole;
      r_prev    <= w_nxt_prev;
      r_leds    <= w_nxt_leds;
      r_active  <= w_nxt_active;
      r_hit     <= w_nxt_hit;
      r_miss    <= w_nxt_miss;
      r_wrong   <= w_nxt_wrong;
    end
  end

  assign o_mole_leds   = r_leds;
  assign o_mole_active = r_active;
  assign o_hit_pulse   = r_hit;
  assign o_miss_pulse  = r_miss;
  assign o_wrong_pulse = r_wrong;

endmodule
